sar_track_timer: RTL and testbench

//  Parametrised successive-approximation (SAR) controller with a built-in conversion timer.

---
 rtl/sar_pkg.sv | 17 +
 rtl/sat_counter.sv | 36 +++
 rtl/sar_track_timer.sv | 176 +++++++++++++++++
 tb/tb_sar_track_timer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types for the SAR/tracking controller: FSM state encoding and Mode field values.
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DECIDE = 3'd2,
    S_DONE   = 3'd3,
    S_TRACK  = 3'd4
  } sar_state_e;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_ONE   = 2'b01;
  localparam logic [1:0] MODE_TRACK = 2'b10;
  localparam logic [1:0] MODE_CONT  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones; sat flags that value.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  assign sat   = (count_q == {W{1'b1}});
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !sat) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sar_track_timer.sv
// SAR / tracking ADC controller with conversion timer. Ready is a one-cycle valid strobe with
// no back-pressure: DataOut, TimerOut and Overflow are stable whenever Ready is high.
module sar_track_timer
  import sar_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1,
  parameter int TMR_W  = 6
) (
  input  logic             ClockT,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic             CmpIn,
  input  logic             Inc,
  input  logic             Dcr,
  output logic [WIDTH-1:0] DacCode,
  output logic [WIDTH-1:0] DataOut,
  output logic             Ready,
  output logic             Busy,
  output logic [TMR_W-1:0] TimerOut,
  output logic             Overflow
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [WIDTH-1:0] MSB_CODE   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_CODE   = {WIDTH{1'b1}};
  localparam logic [BIT_W-1:0] TOP_BIT    = BIT_W'(WIDTH - 1);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE - 1);

  sar_state_e       state_d, state_q;
  logic [WIDTH-1:0] dac_d, dac_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic             ready_d, ready_q;
  logic [TMR_W-1:0] tmr_out_d, tmr_out_q;
  logic             ovf_d, ovf_q;
  logic [BIT_W-1:0] bit_d, bit_q;

  logic             tmr_en;
  logic [TMR_W-1:0] tmr_cnt;
  logic             tmr_sat;
  logic             settle_en;
  logic [SET_W-1:0] settle_cnt;
  logic             settle_sat;
  logic             settle_done;
  logic             sar_start;
  logic             abort;

  assign tmr_en    = (state_q == S_SETTLE) || (state_q == S_DECIDE);
  assign settle_en = (state_q == S_SETTLE);
  // The saturation flag is only a backstop; the count always reaches SETTLE_END first.
  assign settle_done = (settle_cnt == SETTLE_END) || settle_sat;

  sat_counter #(.W(TMR_W)) u_timer (
    .clk   (ClockT),
    .rst_n (ResetN),
    .clr   (!tmr_en),
    .en    (tmr_en),
    .count (tmr_cnt),
    .sat   (tmr_sat)
  );

  sat_counter #(.W(SET_W)) u_settle (
    .clk   (ClockT),
    .rst_n (ResetN),
    .clr   (!settle_en),
    .en    (settle_en),
    .count (settle_cnt),
    .sat   (settle_sat)
  );

  always_comb begin
    state_d   = state_q;
    dac_d     = dac_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    tmr_out_d = tmr_out_q;
    ovf_d     = ovf_q;
    bit_d     = bit_q;
    sar_start = 1'b0;
    // Hold always aborts; switching between tracking and SAR families aborts too.
    abort = (Mode == MODE_HOLD) ||
            ((state_q == S_TRACK) ? (Mode != MODE_TRACK) : (Mode == MODE_TRACK));

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Mode == MODE_TRACK) begin
            state_d = S_TRACK;
            dac_d   = data_q;
          end else if (Mode != MODE_HOLD) begin
            sar_start = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (settle_done) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (!CmpIn) dac_d[bit_q] = 1'b0;
        if (bit_q != '0) begin
          dac_d[bit_q - 1'b1] = 1'b1;
          bit_d   = bit_q - 1'b1;
          state_d = S_SETTLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        data_d    = dac_q;
        ready_d   = 1'b1;
        tmr_out_d = tmr_cnt;
        ovf_d     = tmr_sat;
        if (Mode == MODE_CONT) sar_start = 1'b1;
        else state_d = S_IDLE;
      end
      S_TRACK: begin
        if (Inc && !Dcr && (dac_q != MAX_CODE)) begin
          dac_d   = dac_q + 1'b1;
          data_d  = dac_q + 1'b1;
          ready_d = 1'b1;
        end else if (Dcr && !Inc && (dac_q != '0)) begin
          dac_d   = dac_q - 1'b1;
          data_d  = dac_q - 1'b1;
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sar_start) begin
      state_d = S_SETTLE;
      dac_d   = MSB_CODE;
      bit_d   = TOP_BIT;
    end

    if ((state_q != S_IDLE) && abort) begin
      state_d   = S_IDLE;
      dac_d     = '0;
      data_d    = data_q;
      ready_d   = 1'b0;
      tmr_out_d = tmr_out_q;
      ovf_d     = ovf_q;
      bit_d     = bit_q;
    end
  end

  always_ff @(posedge ClockT) begin
    if (!ResetN) begin
      state_q   <= S_IDLE;
      dac_q     <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      tmr_out_q <= '0;
      ovf_q     <= 1'b0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      dac_q     <= dac_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      tmr_out_q <= tmr_out_d;
      ovf_q     <= ovf_d;
      bit_q     <= bit_d;
    end
  end

  assign DacCode  = dac_q;
  assign DataOut  = data_q;
  assign Ready    = ready_q;
  assign Busy     = (state_q != S_IDLE);
  assign TimerOut = tmr_out_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_sar_track_timer.sv
// Bench for sar_track_timer: default instance (8/1/6) plus a 12/3/4 instance, ideal comparator.
module tb_sar_track_timer;
  import sar_pkg::*;

  localparam int W_A = 8,  S_A = 1, T_A = 6;
  localparam int W_B = 12, S_B = 3, T_B = 4;
  localparam int LAT_A = W_A * (S_A + 1) + 1;
  localparam int LAT_B = W_B * (S_B + 1) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic           a_start, a_cmp, a_inc, a_dcr, a_ready, a_busy, a_ovf;
  logic [1:0]     a_mode;
  logic [W_A-1:0] a_dac, a_data;
  logic [T_A-1:0] a_tmr;
  logic           b_start, b_cmp, b_inc, b_dcr, b_ready, b_busy, b_ovf;
  logic [1:0]     b_mode;
  logic [W_B-1:0] b_dac, b_data;
  logic [T_B-1:0] b_tmr;

  int a_ain = 0, a_last_data = 0, a_last_tmr = 0, a_last_ovf = 0, a_trk = 0;
  int b_ain = 0;
  logic [63:0] a_exp_q[$];
  logic [63:0] b_exp_q[$];

  // ideal comparator: analog input >= DAC code
  assign a_cmp = (a_ain >= int'(a_dac));
  assign b_cmp = (b_ain >= int'(b_dac));

  sar_track_timer #(.WIDTH(W_A), .SETTLE(S_A), .TMR_W(T_A)) u_dut_a (
    .ClockT(clk), .ResetN(rst_n), .Start(a_start), .Mode(a_mode), .CmpIn(a_cmp),
    .Inc(a_inc), .Dcr(a_dcr), .DacCode(a_dac), .DataOut(a_data), .Ready(a_ready),
    .Busy(a_busy), .TimerOut(a_tmr), .Overflow(a_ovf)
  );

  sar_track_timer #(.WIDTH(W_B), .SETTLE(S_B), .TMR_W(T_B)) u_dut_b (
    .ClockT(clk), .ResetN(rst_n), .Start(b_start), .Mode(b_mode), .CmpIn(b_cmp),
    .Inc(b_inc), .Dcr(b_dcr), .DacCode(b_dac), .DataOut(b_data), .Ready(b_ready),
    .Busy(b_busy), .TimerOut(b_tmr), .Overflow(b_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] pack_exp(int at, int ovf, int tmr, int data);
    return {at, 1'(ovf), 15'(tmr), 16'(data)};
  endfunction

  // Reference timer value for a conversion of n counted cycles into a tw-bit timer.
  function automatic int sat_val(int n, int tw);
    int tmax = (1 << tw) - 1;
    return (n >= tmax) ? tmax : n;
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n === 1'b1 && a_ready === 1'b1) begin
      if (a_exp_q.size() == 0) begin
        chk("a_ready_unexpected", 32'(a_ready), 32'd0);
      end else begin
        e = a_exp_q.pop_front();
        chk("a_data", 32'(a_data), 32'(e[15:0]));
        chk("a_timer", 32'(a_tmr), 32'(e[30:16]));
        chk("a_overflow", 32'(a_ovf), 32'(e[31]));
        chk("a_ready_cycle", cyc, e[63:32]);
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n === 1'b1 && b_ready === 1'b1) begin
      if (b_exp_q.size() == 0) begin
        chk("b_ready_unexpected", 32'(b_ready), 32'd0);
      end else begin
        e = b_exp_q.pop_front();
        chk("b_data", 32'(b_data), 32'(e[15:0]));
        chk("b_timer", 32'(b_tmr), 32'(e[30:16]));
        chk("b_overflow", 32'(b_ovf), 32'(e[31]));
        chk("b_ready_cycle", cyc, e[63:32]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push_conv(int at, int val);
    int n = W_A * (S_A + 1);
    a_last_data = val;
    a_last_tmr  = sat_val(n, T_A);
    a_last_ovf  = (n >= (1 << T_A) - 1) ? 1 : 0;
    a_exp_q.push_back(pack_exp(at, a_last_ovf, a_last_tmr, val));
  endtask

  task automatic a_wait_idle();
    int n = 0;
    while (a_busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (a_busy !== 1'b0) chk("a_busy_timeout", 32'(a_busy), 32'd0);
  endtask

  task automatic a_oneshot(int val, int start_len);
    a_ain = val;
    a_mode = MODE_ONE;
    a_start = 1'b1;
    a_push_conv(cyc + 1 + LAT_A, val);
    for (int i = 0; i < start_len; i++) tick();
    a_start = 1'b0;
    chk("a_busy_conv", 32'(a_busy), 32'd1);
    a_wait_idle();
  endtask

  task automatic a_track_enter();
    a_inc = 1'b0;
    a_dcr = 1'b0;
    a_mode = MODE_TRACK;
    a_start = 1'b1;
    a_trk = a_last_data;
    tick();
    a_start = 1'b0;
    chk("a_track_entry_dac", 32'(a_dac), 32'(a_trk));
  endtask

  task automatic a_track_step(logic inc, logic dcr);
    a_inc = inc;
    a_dcr = dcr;
    if (inc && !dcr && a_trk < (1 << W_A) - 1) begin
      a_trk++;
      a_last_data = a_trk;
      a_exp_q.push_back(pack_exp(cyc + 1, a_last_ovf, a_last_tmr, a_trk));
    end else if (dcr && !inc && a_trk > 0) begin
      a_trk--;
      a_last_data = a_trk;
      a_exp_q.push_back(pack_exp(cyc + 1, a_last_ovf, a_last_tmr, a_trk));
    end
    tick();
    chk("a_track_dac", 32'(a_dac), 32'(a_trk));
  endtask

  task automatic a_leave(logic [1:0] m, string name);
    a_inc = 1'b0;
    a_dcr = 1'b0;
    a_mode = m;
    tick();
    chk({name, "_busy"}, 32'(a_busy), 32'd0);
    chk({name, "_dac"}, 32'(a_dac), 32'd0);
    chk({name, "_data"}, 32'(a_data), 32'(a_last_data));
    chk({name, "_timer"}, 32'(a_tmr), 32'(a_last_tmr));
  endtask

  task automatic b_oneshot(int val);
    int n = 0;
    int nconv = W_B * (S_B + 1);
    b_ain = val;
    b_mode = MODE_ONE;
    b_start = 1'b1;
    b_exp_q.push_back(pack_exp(cyc + 1 + LAT_B, (nconv >= (1 << T_B) - 1) ? 1 : 0,
                               sat_val(nconv, T_B), val));
    tick();
    b_start = 1'b0;
    while (b_busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (b_busy !== 1'b0) chk("b_busy_timeout", 32'(b_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    a_start = 1'b0; a_mode = MODE_HOLD; a_inc = 1'b0; a_dcr = 1'b0;
    b_start = 1'b0; b_mode = MODE_HOLD; b_inc = 1'b0; b_dcr = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      a_start = 1'($urandom); a_mode = 2'($urandom); a_inc = 1'($urandom);
      a_dcr = 1'($urandom); a_ain = $urandom_range(0, 255);
      b_start = 1'($urandom); b_mode = 2'($urandom); b_inc = 1'($urandom);
      b_dcr = 1'($urandom); b_ain = $urandom_range(0, 4095);
      tick();
      chk("rst_a_outputs", 32'({a_dac, a_data, a_ready, a_busy, a_tmr, a_ovf}), 32'd0);
      chk("rst_b_outputs", 32'({b_dac, b_data, b_ready, b_busy, b_tmr, b_ovf}), 32'd0);
    end
    a_start = 1'b0; a_mode = MODE_HOLD; a_inc = 1'b0; a_dcr = 1'b0;
    b_start = 1'b0; b_mode = MODE_HOLD; b_inc = 1'b0; b_dcr = 1'b0;
    rst_n = 1'b1;
    tick();

    // Start with Mode=00 is ignored
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_hold_start_busy", 32'(a_busy), 32'd0);

    // one-shot conversions, one with Start held while busy
    a_oneshot(8'hA5, 1);
    a_oneshot(8'h00, 1);
    a_oneshot(8'hFF, 4);

    // continuous: one Start, second conversion ends in one-shot mode
    c0 = cyc;
    a_ain = 8'h10;
    a_mode = MODE_CONT;
    a_start = 1'b1;
    a_push_conv(c0 + 1 + LAT_A, 8'h10);
    tick();
    a_start = 1'b0;
    while (cyc < c0 + 1 + LAT_A) tick();
    chk("a_cont_restart_busy", 32'(a_busy), 32'd1);
    a_ain = 8'h11;
    a_mode = MODE_ONE;
    a_push_conv(c0 + 1 + 2 * LAT_A, 8'h11);
    a_wait_idle();

    // tracking at the top rail
    a_oneshot(8'hFE, 1);
    a_track_enter();
    for (int i = 0; i < 3; i++) a_track_step(1'b1, 1'b0);
    a_track_step(1'b1, 1'b1);
    a_track_step(1'b0, 1'b1);
    a_leave(MODE_HOLD, "a_track_hold");

    // tracking at the bottom rail
    a_oneshot(8'h00, 1);
    a_track_enter();
    a_track_step(1'b0, 1'b1);
    a_track_step(1'b0, 1'b1);
    a_track_step(1'b1, 1'b1);
    a_track_step(1'b0, 1'b0);
    a_leave(MODE_ONE, "a_track_modechg");

    // abort a one-shot at cycle 7
    a_ain = 8'h5A;
    a_mode = MODE_ONE;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (6) tick();
    a_leave(MODE_HOLD, "a_abort");
    repeat (20) tick();

    // reset mid-conversion discards everything
    a_ain = 8'h33;
    a_mode = MODE_ONE;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_a_outputs", 32'({a_dac, a_data, a_ready, a_busy, a_tmr, a_ovf}), 32'd0);
    rst_n = 1'b1;
    a_mode = MODE_HOLD;
    a_last_data = 0; a_last_tmr = 0; a_last_ovf = 0;
    tick();

    // randomized conversions and tracking near the rails
    for (int i = 0; i < 5; i++) a_oneshot($urandom_range(0, 255), 1);
    for (int r = 0; r < 2; r++) begin
      a_oneshot((r == 0) ? $urandom_range(250, 255) : $urandom_range(0, 5), 1);
      a_track_enter();
      for (int i = 0; i < 12; i++) a_track_step(1'($urandom), 1'($urandom));
      a_leave(MODE_ONE, "a_rand_track_exit");
    end

    // wide/slow instance: timer saturates
    b_oneshot(12'h000);
    b_oneshot(12'hFFF);
    for (int i = 0; i < 2; i++) b_oneshot($urandom_range(0, 4095));

    repeat (5) tick();
    chk("a_queue_drained", 32'(a_exp_q.size()), 32'd0);
    chk("b_queue_drained", 32'(b_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
